// File: rtl/baud_rate_gen_frac.sv
// Fractional, runtime-programmable baud-rate generator: oversample tick every
// div_int + div_frac/2^FRAC_W cycles on average, plus a bit tick every OVERSAMPLE ticks.
module baud_rate_gen_frac #(
    parameter int unsigned CNT_W            = 16,
    parameter int unsigned FRAC_W           = 4,
    parameter int unsigned OVERSAMPLE       = 16,
    parameter int unsigned DEFAULT_DIV_INT  = 163,
    parameter int unsigned DEFAULT_DIV_FRAC = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_load,
    input  logic [CNT_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    output logic              o_tick,
    output logic              o_bit_tick,
    output logic              o_load_pending,
    output logic              o_div_err
);

    localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  int_a_q, int_a_d;
    logic [FRAC_W-1:0] frac_a_q, frac_a_d;
    logic [CNT_W-1:0]  int_s_q, int_s_d;
    logic [FRAC_W-1:0] frac_s_q, frac_s_d;
    logic              pending_q, pending_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic              err_q, err_d;

    logic [CNT_W:0]    period_c;
    logic [CNT_W:0]    last_c;
    logic [FRAC_W:0]   acc_sum_c;
    logic              wrap_c;
    logic              load_ok_c;

    // Period is one bit wider so a maximal int_a plus carry cannot overflow.
    always_comb begin
        period_c  = {1'b0, int_a_q} + (CNT_W+1)'(carry_q);
        last_c    = period_c - (CNT_W+1)'(1);
        wrap_c    = i_enable && ({1'b0, cnt_q} == last_c);
        acc_sum_c = {1'b0, acc_q} + {1'b0, frac_a_q};
        load_ok_c = i_load && (i_div_int >= CNT_W'(2));
    end

    always_comb begin
        cnt_d     = cnt_q;
        int_a_d   = int_a_q;
        frac_a_d  = frac_a_q;
        int_s_d   = int_s_q;
        frac_s_d  = frac_s_q;
        pending_d = pending_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        os_cnt_d  = os_cnt_q;
        err_d     = i_load && !load_ok_c;

        if (i_enable) begin
            if (wrap_c) begin
                cnt_d    = '0;
                os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
                carry_d  = acc_sum_c[FRAC_W];
                acc_d    = acc_sum_c[FRAC_W-1:0];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Shadow applies only at a period boundary (or immediately while frozen).
        if (pending_q && (wrap_c || !i_enable)) begin
            int_a_d   = int_s_q;
            frac_a_d  = frac_s_q;
            acc_d     = '0;
            carry_d   = 1'b0;
            os_cnt_d  = '0;
            cnt_d     = '0;
            pending_d = 1'b0;
        end

        if (load_ok_c) begin
            int_s_d   = i_div_int;
            frac_s_d  = i_div_frac;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q     <= '0;
            int_a_q   <= CNT_W'(DEFAULT_DIV_INT);
            frac_a_q  <= FRAC_W'(DEFAULT_DIV_FRAC);
            int_s_q   <= CNT_W'(DEFAULT_DIV_INT);
            frac_s_q  <= FRAC_W'(DEFAULT_DIV_FRAC);
            pending_q <= 1'b0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            os_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            int_a_q   <= int_a_d;
            frac_a_q  <= frac_a_d;
            int_s_q   <= int_s_d;
            frac_s_q  <= frac_s_d;
            pending_q <= pending_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            os_cnt_q  <= os_cnt_d;
            err_q     <= err_d;
        end
    end

    assign o_tick         = wrap_c;
    assign o_bit_tick     = wrap_c && (os_cnt_q == OS_LAST);
    assign o_load_pending = pending_q;
    assign o_div_err      = err_q;

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Scoreboard bench for baud_rate_gen_frac: a tick-index reference model queues
// per-cycle expected outputs; a negedge monitor pops and compares them.
module tb_baud_rate_gen_frac;

    localparam int CNT_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OS     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] di = '0;
    logic [3:0]  df = '0;
    logic        o_tick, o_bit_tick, o_load_pending, o_div_err;

    baud_rate_gen_frac #(
        .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
        .DEFAULT_DIV_INT(163), .DEFAULT_DIV_FRAC(0)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_load(load),
        .i_div_int(di), .i_div_frac(df),
        .o_tick(o_tick), .o_bit_tick(o_bit_tick),
        .o_load_pending(o_load_pending), .o_div_err(o_div_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [3:0] exp_q[$];
    int tick_log[$];

    // Reference model: period k after an apply lasts int + (floor(k*f/2^F) - floor((k-1)*f/2^F)).
    int m_int, m_frac, m_k, m_el, m_sint, m_sfrac;
    bit m_pend, m_err;

    function automatic int carry_of(input int k, input int f);
        if (k == 0) return 0;
        return ((k * f) >> FRAC_W) - (((k - 1) * f) >> FRAC_W);
    endfunction

    task automatic model_reset();
        m_int = 163; m_frac = 0; m_k = 0; m_el = 0; m_pend = 0; m_err = 0;
    endtask

    task automatic step(input bit r, input bit e, input bit l, input int vi, input int vf);
        int per;
        bit tk, bt;
        @(posedge clk); #1;
        rst = r; en = e; load = l; di = 16'(vi); df = 4'(vf);
        cyc++;
        if (r) begin
            model_reset();
            exp_q.push_back(4'b0000);
        end else begin
            per = m_int + carry_of(m_k, m_frac);
            tk  = e && (m_el == per - 1);
            bt  = tk && ((m_k % OS) == OS - 1);
            exp_q.push_back({tk, bt, m_pend, m_err});
            if (e) begin
                if (tk) begin m_el = 0; m_k++; end
                else m_el++;
            end
            if (m_pend && (tk || !e)) begin
                m_int = m_sint; m_frac = m_sfrac; m_k = 0; m_el = 0; m_pend = 0;
            end
            m_err = l && (vi < 2);
            if (l && vi >= 2) begin m_sint = vi; m_sfrac = vf; m_pend = 1; end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
    endtask

    task automatic run_to_el(input int target);
        int budget = 100000;
        while (m_el != target && budget > 0) begin
            step(0, 1, 0, 0, 0);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL run_to_el timeout: got elapsed %0d want %0d", m_el, target);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation for this cycle.
    always @(negedge clk) begin
        logic [3:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {o_tick, o_bit_tick, o_load_pending, o_div_err};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL outputs cycle %0d tick/bit/pend/err got %b want %b", cyc, g, e);
            end
            if (o_tick) tick_log.push_back(cyc);
        end
    end

    initial begin
        model_reset();
        // 1: defaults, 20+ ticks at 163 with bit tick on every 16th
        step(1, 1, 0, 0, 0);
        run(163 * 20 + 10);

        // 2: fractional 10 + 8/16 loaded while running
        run_to_el(5);
        tick_log.delete();
        step(0, 1, 1, 10, 8);
        run(600);
        n_cmp++;
        if (tick_log.size() < 34) begin
            n_bad++;
            $display("FAIL frac_span tick count got %0d want >= 34", tick_log.size());
        end else if (tick_log[33] - tick_log[1] != 336) begin
            n_bad++;
            $display("FAIL frac_span 32 ticks got %0d cycles want 336", tick_log[33] - tick_log[1]);
        end

        // 3: back to 163, then load 50 mid-period at cnt 20
        step(0, 1, 1, 163, 0);
        run(40);
        run_to_el(20);
        step(0, 1, 1, 50, 0);
        run(50 * 20 + 200);

        // 4: rejected loads with int 1 and 0 at period 163
        step(0, 1, 1, 163, 0);
        run(60);
        step(0, 1, 1, 1, 5);
        run(3);
        step(0, 1, 1, 0, 0);
        run(400);

        // 5: disable 40 cycles at cnt 100, then a load while disabled
        run_to_el(100);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0);
        run(250);
        run_to_el(30);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 20, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        run(400);

        // 6: reset at cnt 80 with a load pending
        step(0, 1, 1, 163, 0);
        run(60);
        run_to_el(60);
        step(0, 1, 1, 70, 2);
        run_to_el(80);
        step(1, 1, 0, 0, 0);
        run(400);

        // Random phase: enables, valid and invalid loads, small divisors
        for (int i = 0; i < 4000; i++) begin
            bit e, l;
            e = ($urandom % 8) != 0;
            l = ($urandom % 40) == 0;
            step(0, e, l, int'($urandom_range(0, 20)), int'($urandom_range(0, 15)));
        end
        run(5);

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
